alu_ex_result_stage: RTL and testbench
======================================

// Module: alu_ex_result_stage
// PURPOSE
//  EX->MEM hand-off stage directly downstream of the 32-bit ripple ALU built from 1-bit ALU slices.
//  Captures ALU result, MSB overflow (v) and destination info in a 2-entry skid buffer.
//  Uses a valid/ready handshake on both sides and derives the zero flag.
//  Converts signed overflow into a precise arithmetic-overflow exception record for the CP0 logic.
// PARAMETERS
//  WIDTH  32  datapath width (matches ALU slice count)
//  REGW   5   destination register index width
//  PCW    32  program counter width
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high reset
//  flush         in   1      synchronous pipeline flush (branch/exception redirect)
//  in_valid      in   1      ALU outputs + sideband valid this cycle
//  in_ready      out  1      stage can accept; registered, = (count<2) & ~exc_pending
//  alu_out       in   WIDTH  ALU result bus
//  alu_v         in   1      overflow from MSB slice (cin^cout)
//  ovf_trap      in   1      op is trapping signed (add/sub/addi); 0 for addu/subu/logic/slt
//  in_dest       in   REGW   destination register
//  in_wen        in   1      register write enable
//  in_pc         in   PCW    PC of the instruction
//  out_valid     out  1      head entry valid
//  out_ready     in   1      MEM stage accepts head
//  out_result    out  WIDTH  head result
//  out_zero      out  1      head result == 0
//  out_ovf       out  1      head entry overflowed (non-trapping record)
//  out_dest      out  REGW   head destination
//  out_wen       out  1      head write enable
//  exc_pending   out  1      overflow exception latched, awaiting ack
//  exc_epc       out  PCW    PC of faulting instruction
//  exc_cause     out  5      exception code (12 = Ov)
//  exc_ack       in   1      CP0 consumed exception record
// BEHAVIOUR
//  - Reset: count=0, all out_* = 0, in_ready=1, exc_pending=0, exc_epc=0, exc_cause=0.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready. Latency: push at edge N -> out_valid at N+1.
//  - Buffer is a 2-entry FIFO (head/tail pointers, 1-bit each, wrap at 2). out_* driven from head register.
//  - out_zero is computed at capture (~|alu_out) and stored, not recomputed at output.
//  - push+pop same cycle with count=1: count stays 1, new entry becomes head on the next cycle.
//  - push+pop same cycle with count=0: new entry appears next cycle; no combinational bypass.
//  - count=2: in_ready=0; upstream must hold. pop alone returns count to 1 and raises in_ready next cycle.
//  - in_ready is a registered output only. No combinational path from out_ready to in_ready.
//  - Priority: reset > flush > (push, pop).
//  - flush: count=0, out_valid=0 next cycle, in-flight push discarded. exc_* registers are untouched by flush.
//  - States: IDLE (count 0), HALF (1), FULL (2), EXC (exc_pending=1, orthogonal to count).
//  - exc_ack while exc_pending: clears exc_pending next cycle; epc/cause hold their values.
//  - exc_ack while not pending: ignored.
// CONFIGURATION
//  Macro ALU_OVF_TRAP_EN:
//  - Defined, push with ovf_trap & alu_v:
//    - Entry is NOT enqueued, so no register write occurs.
//    - Next cycle: exc_pending=1, exc_epc=in_pc, exc_cause=12, in_ready=0 until exc_ack.
//    - Entries already buffered drain normally.
//    - A non-trapping overflow (ovf_trap=0) enqueues with out_ovf=1.
//  - Undefined:
//    - Every push is enqueued. out_ovf=alu_v & ovf_trap.
//    - exc_pending, exc_epc and exc_cause are tied to 0; exc_ack is ignored.
// TESTING
//  1. Reset then push alu_out=0x0000_0005, dest=3, out_ready=1 -> next cycle out_valid=1,
//     out_result=5, out_zero=0, out_dest=3; then out_valid=0.
//  2. out_ready=0, push 0x0, then 0x7 -> count=2, in_ready=0, head out_zero=1.
//     Raise out_ready -> results 0x0 then 0x7 in order; in_ready back to 1.
//  3. count=1 with continuous push+pop for 8 cycles (values 1..8) -> count stays 1, outputs 1..8 in order, none lost.
//  4. count=2, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; flushed push never appears.
//  5. [ALU_OVF_TRAP_EN] push 0x7FFF_FFFF+1 result, alu_v=1, ovf_trap=1, pc=0x0040_0020
//     -> no out_valid for it, exc_pending=1, exc_epc=0x0040_0020, exc_cause=12, in_ready=0;
//     exc_ack -> exc_pending=0 next cycle.
//  6. Same stimulus with ovf_trap=0 (addu) -> enqueued, out_result=0x8000_0000, out_ovf=1, exc_pending stays 0.

Source files
------------

// File: rtl/alu_ex_result_stage.sv
// EX->MEM result stage: 2-entry skid buffer; out_zero is taken from the captured result; ALU_OVF_TRAP_EN turns trapping signed overflow into a CP0 exception record.
// Latency 1 cycle from push to out_valid; in_ready is registered and falls when the buffer is full or an exception is pending.
module alu_ex_result_stage #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5,
   parameter int PCW   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_v,
   input  logic             ovf_trap,
   input  logic [REGW-1:0]  in_dest,
   input  logic             in_wen,
   input  logic [PCW-1:0]   in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_ovf,
   output logic [REGW-1:0]  out_dest,
   output logic             out_wen,
   output logic             exc_pending,
   output logic [PCW-1:0]   exc_epc,
   output logic [4:0]       exc_cause,
   input  logic             exc_ack
);

   localparam logic [4:0] EXC_OV = 5'd12;

   // Occupancy of the skid buffer; the exception flag is tracked separately.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HALF = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t state, state_n;

   logic             head, tail;
   logic [WIDTH-1:0] ent_result [2];
   logic             ent_zero   [2];
   logic             ent_ovf    [2];
   logic [REGW-1:0]  ent_dest   [2];
   logic             ent_wen    [2];

   logic push, pop, trap, enq, in_ovf;
   logic exc_n, in_ready_n;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

`ifdef ALU_OVF_TRAP_EN
   // A trapping overflow never reaches the buffer, so no register write can follow it.
   assign trap   = push & ovf_trap & alu_v;
   assign enq    = push & ~trap;
   assign in_ovf = alu_v & ~ovf_trap;
`else
   assign trap   = 1'b0;
   assign enq    = push;
   assign in_ovf = alu_v & ovf_trap;
`endif

   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    state_n = enq ? HALF : IDLE;
            HALF: begin
               if (enq && !pop)      state_n = FULL;
               else if (!enq && pop) state_n = IDLE;
               else                  state_n = HALF;
            end
            FULL:    state_n = pop ? HALF : FULL;
            default: state_n = IDLE;
         endcase
      end
   end

   // A flush discards an in-flight trap too, but leaves a latched exception alone.
   always_comb begin
      exc_n = exc_pending;
      if (exc_pending)
         exc_n = ~exc_ack;
      else if (trap && !flush)
         exc_n = 1'b1;
      in_ready_n = (state_n != FULL) & ~exc_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         head        <= 1'b0;
         tail        <= 1'b0;
         in_ready    <= 1'b1;
         exc_pending <= 1'b0;
         exc_epc     <= '0;
         exc_cause   <= '0;
         for (int i = 0; i < 2; i++) begin
            ent_result[i] <= '0;
            ent_zero[i]   <= 1'b0;
            ent_ovf[i]    <= 1'b0;
            ent_dest[i]   <= '0;
            ent_wen[i]    <= 1'b0;
         end
      end else begin
         state       <= state_n;
         in_ready    <= in_ready_n;
         exc_pending <= exc_n;
         if (flush) begin
            head <= 1'b0;
            tail <= 1'b0;
         end else begin
            if (enq) begin
               ent_result[tail] <= alu_out;
               ent_zero[tail]   <= ~|alu_out;
               ent_ovf[tail]    <= in_ovf;
               ent_dest[tail]   <= in_dest;
               ent_wen[tail]    <= in_wen;
               tail             <= ~tail;
            end
            if (pop)
               head <= ~head;
            if (trap && !exc_pending) begin
               exc_epc   <= in_pc;
               exc_cause <= EXC_OV;
            end
         end
      end
   end

   assign out_valid  = (state != IDLE);
   assign out_result = ent_result[head];
   assign out_zero   = ent_zero[head];
   assign out_ovf    = ent_ovf[head];
   assign out_dest   = ent_dest[head];
   assign out_wen    = ent_wen[head];

endmodule

// File: tb/tb_alu_ex_result_stage.sv
// Directed bench for alu_ex_result_stage: a stimulus process queues expected entries, a monitor checks each handshake.
module tb_alu_ex_result_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready;
   logic [31:0] alu_out;
   logic        alu_v, ovf_trap;
   logic [4:0]  in_dest;
   logic        in_wen;
   logic [31:0] in_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic        out_zero, out_ovf;
   logic [4:0]  out_dest;
   logic        out_wen;
   logic        exc_pending;
   logic [31:0] exc_epc;
   logic [4:0]  exc_cause;
   logic        exc_ack;

   alu_ex_result_stage #(.WIDTH(32), .REGW(5), .PCW(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .alu_v(alu_v), .ovf_trap(ovf_trap),
      .in_dest(in_dest), .in_wen(in_wen), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
      .out_dest(out_dest), .out_wen(out_wen),
      .exc_pending(exc_pending), .exc_epc(exc_epc), .exc_cause(exc_cause),
      .exc_ack(exc_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic [4:0]  dest;
      logic        wen;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic expect_out(input logic [31:0] res, input logic zero, input logic ovf,
                             input logic [4:0] dest, input logic wen);
      exp_t e;
      e.res = res; e.zero = zero; e.ovf = ovf; e.dest = dest; e.wen = wen;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [31:0] val, input logic v, input logic trp,
                        input logic [4:0] dest, input logic [31:0] pc);
      in_valid = 1'b1; alu_out = val; alu_v = v; ovf_trap = trp;
      in_dest = dest; in_wen = 1'b1; in_pc = pc;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Monitor: every accepted head entry must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out: got result 0x%0h with no entry expected", out_result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_result", {32'd0, out_result}, {32'd0, e.res});
            chk("out_zero",   {63'd0, out_zero},   {63'd0, e.zero});
            chk("out_ovf",    {63'd0, out_ovf},    {63'd0, e.ovf});
            chk("out_dest",   {59'd0, out_dest},   {59'd0, e.dest});
            chk("out_wen",    {63'd0, out_wen},    {63'd0, e.wen});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_out = '0; alu_v = 1'b0;
      ovf_trap = 1'b0; in_dest = '0; in_wen = 1'b0; in_pc = '0;
      out_ready = 1'b0; exc_ack = 1'b0;
      step(); step();
      reset = 1'b0;
      step();

      // reset state
      chk("rst_out_valid",   {63'd0, out_valid},   64'd0);
      chk("rst_in_ready",    {63'd0, in_ready},    64'd1);
      chk("rst_exc_pending", {63'd0, exc_pending}, 64'd0);
      chk("rst_exc_epc",     {32'd0, exc_epc},     64'd0);
      chk("rst_exc_cause",   {59'd0, exc_cause},   64'd0);
      chk("rst_out_result",  {32'd0, out_result},  64'd0);

      // 1: single push with consumer ready
      out_ready = 1'b1;
      drive(32'h0000_0005, 1'b0, 1'b0, 5'd3, 32'h0040_0000);
      expect_out(32'h5, 1'b0, 1'b0, 5'd3, 1'b1);
      step();
      in_valid = 1'b0;
      chk("t1_out_valid_on", {63'd0, out_valid}, 64'd1);
      step();
      chk("t1_out_valid_off", {63'd0, out_valid}, 64'd0);

      // 2: fill both entries while stalled, then drain in order
      out_ready = 1'b0;
      drive(32'h0, 1'b0, 1'b0, 5'd4, 32'h0040_0004);
      expect_out(32'h0, 1'b1, 1'b0, 5'd4, 1'b1);
      step();
      drive(32'h7, 1'b0, 1'b0, 5'd5, 32'h0040_0008);
      expect_out(32'h7, 1'b0, 1'b0, 5'd5, 1'b1);
      step();
      in_valid = 1'b0;
      chk("t2_full_in_ready", {63'd0, in_ready},  64'd0);
      chk("t2_full_valid",    {63'd0, out_valid}, 64'd1);
      chk("t2_head_zero",     {63'd0, out_zero},  64'd1);
      out_ready = 1'b1;
      step();
      chk("t2_half_in_ready", {63'd0, in_ready}, 64'd1);
      step();
      chk("t2_drained_valid", {63'd0, out_valid}, 64'd0);
      chk("t2_drained_ready", {63'd0, in_ready},  64'd1);

      // 3: steady push+pop with one entry resident
      out_ready = 1'b0;
      drive(32'd1, 1'b0, 1'b0, 5'd1, 32'h0040_0010);
      expect_out(32'd1, 1'b0, 1'b0, 5'd1, 1'b1);
      step();
      out_ready = 1'b1;
      for (int i = 2; i <= 8; i++) begin
         drive(i, 1'b0, 1'b0, 5'(i), 32'h0040_0010);
         expect_out(i, 1'b0, 1'b0, 5'(i), 1'b1);
         step();
         chk("t3_valid_held", {63'd0, out_valid}, 64'd1);
         chk("t3_ready_held", {63'd0, in_ready},  64'd1);
      end
      in_valid = 1'b0;
      step();
      chk("t3_drained", {63'd0, out_valid}, 64'd0);

      // 4: flush while full, with a push presented
      out_ready = 1'b0;
      drive(32'hA, 1'b0, 1'b0, 5'd10, 32'h0);
      step();
      drive(32'hB, 1'b0, 1'b0, 5'd11, 32'h0);
      step();
      drive(32'hDEAD, 1'b0, 1'b0, 5'd12, 32'h0);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("t4_flush_valid", {63'd0, out_valid}, 64'd0);
      chk("t4_flush_ready", {63'd0, in_ready},  64'd1);
      // flush with one entry and an accepted push in the same cycle
      drive(32'hC, 1'b0, 1'b0, 5'd13, 32'h0);
      step();
      drive(32'hBEEF, 1'b0, 1'b0, 5'd14, 32'h0);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("t4b_flush_valid", {63'd0, out_valid}, 64'd0);
      out_ready = 1'b1;
      step(); step(); step();
      chk("t4_nothing_after", {63'd0, out_valid}, 64'd0);

      // 5: trapping signed overflow
      drive(32'h8000_0000, 1'b1, 1'b1, 5'd8, 32'h0040_0020);
`ifndef ALU_OVF_TRAP_EN
      expect_out(32'h8000_0000, 1'b0, 1'b1, 5'd8, 1'b1);
`endif
      step();
      in_valid = 1'b0;
`ifdef ALU_OVF_TRAP_EN
      chk("t5_no_valid",    {63'd0, out_valid},   64'd0);
      chk("t5_exc_pending", {63'd0, exc_pending}, 64'd1);
      chk("t5_exc_epc",     {32'd0, exc_epc},     64'h0040_0020);
      chk("t5_exc_cause",   {59'd0, exc_cause},   64'd12);
      chk("t5_in_ready",    {63'd0, in_ready},    64'd0);
      step();
      chk("t5_still_pending", {63'd0, exc_pending}, 64'd1);
      exc_ack = 1'b1;
      step();
      exc_ack = 1'b0;
      chk("t5_ack_clears", {63'd0, exc_pending}, 64'd0);
      chk("t5_epc_holds",  {32'd0, exc_epc},     64'h0040_0020);
      chk("t5_cause_hold", {59'd0, exc_cause},   64'd12);
      chk("t5_ready_back", {63'd0, in_ready},    64'd1);
`else
      chk("t5_exc_tied",   {63'd0, exc_pending}, 64'd0);
      chk("t5_epc_tied",   {32'd0, exc_epc},     64'd0);
      chk("t5_cause_tied", {59'd0, exc_cause},   64'd0);
      exc_ack = 1'b1;
      step();
      exc_ack = 1'b0;
`endif
      // ack with nothing pending is ignored
      exc_ack = 1'b1;
      step();
      exc_ack = 1'b0;
      chk("t5_idle_ack", {63'd0, exc_pending}, 64'd0);

      // 6: non-trapping overflow (addu)
      drive(32'h8000_0000, 1'b1, 1'b0, 5'd9, 32'h0040_0020);
`ifdef ALU_OVF_TRAP_EN
      expect_out(32'h8000_0000, 1'b0, 1'b1, 5'd9, 1'b1);
`else
      expect_out(32'h8000_0000, 1'b0, 1'b0, 5'd9, 1'b1);
`endif
      step();
      in_valid = 1'b0;
      chk("t6_valid",       {63'd0, out_valid},   64'd1);
      chk("t6_no_exc",      {63'd0, exc_pending}, 64'd0);
      step(); step();

      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL sb_empty: %0d entries never appeared, expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
